match_ctrl: RTL and testbench

- Game-flow sequencer for the volleyball match: IDLE -> SERVE -> RALLY -> POINT pause -> SERVE ... -> OVER.
- Consumes fault events from ball physics and judging (ground hit, over-touch); owns both scores.
- Drives ball reset, serving side and the play enable that gates ball_pos_ctrl and the player movers.
- Sits in the pclk (65 MHz) domain beside ball_pos_ctrl; scores feed draw_background.

---
 rtl/match_ctrl_if.sv | 41 ++++
 rtl/match_ctrl.sv | 162 ++++++++++++++++
 tb/tb_match_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_ctrl_if.sv
// match_ctrl_if: game-flow bus between match_ctrl and its neighbours.
// master drives fault/frame inputs, slave is the sequencer.
interface match_ctrl_if #(
  parameter int SCORE_W = 5
);
  logic               vsync_in;
  logic               start_click;
  logic               gnd_col;
  logic               gnd_side;
  logic               ovr_touch;
  logic               last_touch;
  logic               play_en;
  logic               ball_rst;
  logic               serve_side;
  logic [SCORE_W-1:0] score_pl1;
  logic [SCORE_W-1:0] score_pl2;
  logic               flag_point;
  logic               point_winner;
  logic               endgame;
  logic [2:0]         state_out;

  modport master (
    output vsync_in, start_click,
    output gnd_col, gnd_side,
    output ovr_touch, last_touch,
    input  play_en, ball_rst, serve_side,
    input  score_pl1, score_pl2,
    input  flag_point, point_winner,
    input  endgame, state_out
  );

  modport slave (
    input  vsync_in, start_click,
    input  gnd_col, gnd_side,
    input  ovr_touch, last_touch,
    output play_en, ball_rst, serve_side,
    output score_pl1, score_pl2,
    output flag_point, point_winner,
    output endgame, state_out
  );
endinterface

// File: rtl/match_ctrl.sv
// match_ctrl: volleyball match sequencer (serve/rally/point/over).
// Optional WIN_BY_TWO_EN: match ends only with a 2-point lead.
module match_ctrl #(
  parameter int WIN_SCORE    = 15,
  parameter int PAUSE_FRAMES = 90,
  parameter int SERVE_FRAMES = 30,
  parameter int SCORE_W      = 5
) (
  input  logic       pclk,
  input  logic       rst,
  match_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] SC_MAX = '1;
  localparam logic [7:0] SRV_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] PSE_N = 8'(PAUSE_FRAMES);
  localparam logic [SCORE_W:0] WIN_N =
    (SCORE_W+1)'(WIN_SCORE);

  state_t             r_state;
  state_t             w_state_n;
  logic               r_vsync_q;
  logic               r_click_q;
  logic [7:0]         r_cnt;
  logic [SCORE_W-1:0] r_sc1;
  logic [SCORE_W-1:0] r_sc2;
  logic               r_flag;
  logic               r_pw;
  logic               r_serve;

  logic               w_tick;
  logic               w_click;
  logic               w_evt;
  logic               w_win;
  logic               w_award;
  logic               w_clr;
  logic               w_done;
  logic [7:0]         w_cnt_inc;
  logic [SCORE_W:0]   w_sc_w;
  logic [SCORE_W:0]   w_sc_l;

  assign w_tick    = bus.vsync_in & ~r_vsync_q;
  assign w_click   = bus.start_click & ~r_click_q;
  assign w_evt     = bus.gnd_col | bus.ovr_touch;
  assign w_win     = bus.gnd_col ? ~bus.gnd_side
                                 : ~bus.last_touch;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_sc_w    = {1'b0, r_pw ? r_sc2 : r_sc1};
  assign w_sc_l    = {1'b0, r_pw ? r_sc1 : r_sc2};

`ifdef WIN_BY_TWO_EN
  assign w_done = (r_sc1 == SC_MAX) |
                  (r_sc2 == SC_MAX) |
                  ((w_sc_w >= WIN_N) &
                   (w_sc_w >= w_sc_l + (SCORE_W+1)'(2)));
`else
  assign w_done = w_sc_w >= WIN_N;
`endif

  // state register
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  // next-state and per-cycle strobes
  always_comb begin
    w_state_n = r_state;
    w_award   = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_click) w_state_n = S_SERVE;
      S_SERVE:
        if (w_tick && w_cnt_inc == SRV_N)
          w_state_n = S_RALLY;
      S_RALLY:
        if (w_evt) begin
          w_award   = 1'b1;
          w_state_n = S_POINT;
        end
      S_POINT:
        if (w_tick && w_cnt_inc == PSE_N)
          w_state_n = w_done ? S_OVER : S_SERVE;
      S_OVER:
        if (w_click) begin
          w_clr     = 1'b1;
          w_state_n = S_IDLE;
        end
      default:
        w_state_n = S_IDLE;
    endcase
  end

  // frame and click edge detectors
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_vsync_q <= 1'b0;
      r_click_q <= 1'b0;
    end else begin
      r_vsync_q <= bus.vsync_in;
      r_click_q <= bus.start_click;
    end
  end

  // frame counter restarts on every state change
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)
      r_cnt <= 8'd0;
    else if (w_state_n != r_state)
      r_cnt <= 8'd0;
    else if (w_tick && (r_state == S_SERVE ||
                        r_state == S_POINT))
      r_cnt <= w_cnt_inc;
  end

  // scores, point pulse, winner and serving side
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_sc1   <= '0;
      r_sc2   <= '0;
      r_flag  <= 1'b0;
      r_pw    <= 1'b0;
      r_serve <= 1'b0;
    end else begin
      r_flag <= w_award;
      if (w_award) begin
        r_pw    <= w_win;
        r_serve <= w_win;
        if (w_win) begin
          if (r_sc2 != SC_MAX) r_sc2 <= r_sc2 + 1'b1;
        end else begin
          if (r_sc1 != SC_MAX) r_sc1 <= r_sc1 + 1'b1;
        end
      end else if (w_clr) begin
        r_sc1 <= '0;
        r_sc2 <= '0;
      end
    end
  end

  assign bus.play_en      = (r_state == S_RALLY);
  assign bus.ball_rst     = (r_state == S_IDLE) |
                            (r_state == S_SERVE) |
                            (r_state == S_OVER);
  assign bus.endgame      = (r_state == S_OVER);
  assign bus.state_out    = r_state;
  assign bus.serve_side   = r_serve;
  assign bus.score_pl1    = r_sc1;
  assign bus.score_pl2    = r_sc2;
  assign bus.flag_point   = r_flag;
  assign bus.point_winner = r_pw;

endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed match scenarios checked against
// a frame-countdown model of the game rules.
module tb_match_ctrl;

  localparam int WIN  = 15;
  localparam int PSE  = 90;
  localparam int SRV  = 30;
  localparam int SW   = 5;
  localparam int SMAX = (1 << SW) - 1;

  logic pclk;
  logic rst;

  match_ctrl_if #(.SCORE_W(SW)) bus ();

  match_ctrl #(
    .WIN_SCORE(WIN),
    .PAUSE_FRAMES(PSE),
    .SERVE_FRAMES(SRV),
    .SCORE_W(SW)
  ) u_dut (
    .pclk(pclk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // vsync toggles each cycle: one frame tick every 2 cycles
  initial begin
    bus.vsync_in = 1'b0;
    forever begin
      @(negedge pclk);
      bus.vsync_in = ~bus.vsync_in;
    end
  end

  typedef struct {
    int ph;
    int left;
    int s1;
    int s2;
    bit vq;
    bit cq;
    bit flag;
    bit pw;
    bit ss;
  } m_t;

  m_t m;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  function automatic m_t m_reset();
    m_t r;
    r.ph = 0; r.left = 0; r.s1 = 0; r.s2 = 0;
    r.vq = 0; r.cq = 0; r.flag = 0; r.pw = 0; r.ss = 0;
    return r;
  endfunction

  function automatic bit m_over(m_t s);
    int w;
    int l;
    w = s.pw ? s.s2 : s.s1;
    l = s.pw ? s.s1 : s.s2;
`ifdef WIN_BY_TWO_EN
    return (s.s1 == SMAX) || (s.s2 == SMAX) ||
           (w >= WIN && w - l >= 2);
`else
    return w >= WIN;
`endif
  endfunction

  function automatic m_t m_step(m_t s, bit v, bit c,
                                bit g, bit gs,
                                bit o, bit lt);
    m_t n;
    bit tk;
    bit ce;
    bit w;
    n = s;
    tk = v && !s.vq;
    ce = c && !s.cq;
    n.vq = v;
    n.cq = c;
    n.flag = 0;
    case (s.ph)
      0: if (ce) begin n.ph = 1; n.left = SRV; end
      1: if (tk) begin
           n.left = s.left - 1;
           if (n.left == 0) n.ph = 2;
         end
      2: if (g || o) begin
           w = g ? !gs : !lt;
           if (w) n.s2 = (s.s2 < SMAX) ? s.s2 + 1 : SMAX;
           else   n.s1 = (s.s1 < SMAX) ? s.s1 + 1 : SMAX;
           n.flag = 1; n.pw = w; n.ss = w;
           n.ph = 3; n.left = PSE;
         end
      3: if (tk) begin
           n.left = s.left - 1;
           if (n.left == 0) begin
             n.ph = m_over(s) ? 4 : 1;
             n.left = SRV;
           end
         end
      4: if (ce) begin n.ph = 0; n.s1 = 0; n.s2 = 0; end
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  always @(posedge pclk or negedge rst) begin
    if (!rst) m <= m_reset();
    else m <= m_step(m, bus.vsync_in, bus.start_click,
                     bus.gnd_col, bus.gnd_side,
                     bus.ovr_touch, bus.last_touch);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge pclk);
      #1;
      if (chk_en) begin
        chk("m_state", 32'(bus.state_out), 32'(m.ph));
        chk("m_play_en", 32'(bus.play_en), 32'(m.ph == 2));
        chk("m_ball_rst", 32'(bus.ball_rst),
            32'(m.ph == 0 || m.ph == 1 || m.ph == 4));
        chk("m_endgame", 32'(bus.endgame), 32'(m.ph == 4));
        chk("m_serve", 32'(bus.serve_side), 32'(m.ss));
        chk("m_sc1", 32'(bus.score_pl1), 32'(m.s1));
        chk("m_sc2", 32'(bus.score_pl2), 32'(m.s2));
        chk("m_flag", 32'(bus.flag_point), 32'(m.flag));
        chk("m_pw", 32'(bus.point_winner), 32'(m.pw));
      end
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic click();
    bus.start_click = 1'b1;
    cyc(1);
    bus.start_click = 1'b0;
    cyc(1);
  endtask

  task automatic wait_st(int st, int budget);
    int k;
    k = 0;
    while (bus.state_out !== 3'(st) && k < budget) begin
      cyc(1);
      k++;
    end
    chk("wait_state", 32'(bus.state_out), 32'(st));
  endtask

  task automatic leave_point();
    int k;
    k = 0;
    while (bus.state_out === 3'd3 && k < 400) begin
      cyc(1);
      k++;
    end
    chk("pause_end", 32'(bus.state_out != 3'd3), 32'd1);
  endtask

  // ground hit on the loser's half gives w the point
  task automatic point(bit w, bit go_on);
    wait_st(2, 400);
    bus.gnd_col  = 1'b1;
    bus.gnd_side = ~w;
    cyc(1);
    bus.gnd_col  = 1'b0;
    chk("pt_state", 32'(bus.state_out), 32'd3);
    if (go_on) leave_point();
  endtask

  initial begin
    int nflag;
    bus.start_click = 0;
    bus.gnd_col     = 0;
    bus.gnd_side    = 0;
    bus.ovr_touch   = 0;
    bus.last_touch  = 0;
    rst = 1'b0;
    fork
      compare_loop();
    join_none
    cyc(3);
    rst = 1'b1;
    chk_en = 1;
    cyc(2);
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_ball_rst", 32'(bus.ball_rst), 32'd1);
    chk("rst_play_en", 32'(bus.play_en), 32'd0);
    chk("rst_sc1", 32'(bus.score_pl1), 32'd0);

    bus.start_click = 1'b1;
    cyc(1);
    bus.start_click = 1'b0;
    chk("click_serve", 32'(bus.state_out), 32'd1);
    wait_st(2, 200);
    chk("rally_play_en", 32'(bus.play_en), 32'd1);
    chk("rally_ball_rst", 32'(bus.ball_rst), 32'd0);

    // held ground hit on player1 half scores once
    bus.gnd_col  = 1'b1;
    bus.gnd_side = 1'b0;
    cyc(1);
    chk("gnd_flag", 32'(bus.flag_point), 32'd1);
    chk("gnd_sc2", 32'(bus.score_pl2), 32'd1);
    chk("gnd_serve", 32'(bus.serve_side), 32'd1);
    chk("gnd_pw", 32'(bus.point_winner), 32'd1);
    chk("gnd_state", 32'(bus.state_out), 32'd3);
    nflag = 1;
    repeat (19) begin
      cyc(1);
      if (bus.flag_point) nflag++;
    end
    bus.gnd_col = 1'b0;
    chk("gnd_once", 32'(nflag), 32'd1);
    chk("gnd_sc2_held", 32'(bus.score_pl2), 32'd1);
    wait_st(1, 400);

    // simultaneous faults: ground hit has priority
    wait_st(2, 200);
    bus.gnd_col    = 1'b1;
    bus.gnd_side   = 1'b1;
    bus.ovr_touch  = 1'b1;
    bus.last_touch = 1'b1;
    cyc(1);
    bus.gnd_col   = 1'b0;
    bus.ovr_touch = 1'b0;
    chk("prio_sc1", 32'(bus.score_pl1), 32'd1);
    chk("prio_sc2", 32'(bus.score_pl2), 32'd1);
    chk("prio_pw", 32'(bus.point_winner), 32'd0);
    chk("prio_serve", 32'(bus.serve_side), 32'd0);
    leave_point();

    // over-touch alone: the other side wins
    wait_st(2, 200);
    bus.ovr_touch  = 1'b1;
    bus.last_touch = 1'b0;
    cyc(1);
    bus.ovr_touch = 1'b0;
    chk("ovr_sc2", 32'(bus.score_pl2), 32'd2);
    chk("ovr_pw", 32'(bus.point_winner), 32'd1);
    leave_point();

    // player1 runs to 15 (from 1:2)
    for (int i = 0; i < 14; i++) begin
      point(1'b0, 1'b1);
      if (i < 13)
        chk("run_serve", 32'(bus.state_out), 32'd1);
    end
    chk("win_state", 32'(bus.state_out), 32'd4);
    chk("win_endgame", 32'(bus.endgame), 32'd1);
    chk("win_sc1", 32'(bus.score_pl1), 32'd15);
    chk("win_sc2", 32'(bus.score_pl2), 32'd2);
    chk("win_ball_rst", 32'(bus.ball_rst), 32'd1);
    click();
    chk("restart_state", 32'(bus.state_out), 32'd0);
    chk("restart_sc1", 32'(bus.score_pl1), 32'd0);
    chk("restart_sc2", 32'(bus.score_pl2), 32'd0);

`ifdef WIN_BY_TWO_EN
    click();
    for (int i = 0; i < 14; i++) begin
      point(1'b0, 1'b1);
      point(1'b1, 1'b1);
    end
    point(1'b0, 1'b1);
    chk("w2_15_14_state", 32'(bus.state_out), 32'd1);
    chk("w2_sc1", 32'(bus.score_pl1), 32'd15);
    point(1'b0, 1'b1);
    chk("w2_16_14_state", 32'(bus.state_out), 32'd4);
    chk("w2_sc1_end", 32'(bus.score_pl1), 32'd16);
    chk("w2_sc2_end", 32'(bus.score_pl2), 32'd14);
    click();
`endif

    // async reset in the middle of a pause at 3:2
    click();
    point(1'b0, 1'b1);
    point(1'b1, 1'b1);
    point(1'b0, 1'b1);
    point(1'b1, 1'b1);
    point(1'b0, 1'b0);
    chk("pre_rst_sc1", 32'(bus.score_pl1), 32'd3);
    chk("pre_rst_sc2", 32'(bus.score_pl2), 32'd2);
    cyc(5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state_out), 32'd0);
    chk("arst_sc1", 32'(bus.score_pl1), 32'd0);
    chk("arst_sc2", 32'(bus.score_pl2), 32'd0);
    chk("arst_ball_rst", 32'(bus.ball_rst), 32'd1);
    chk("arst_play_en", 32'(bus.play_en), 32'd0);
    cyc(3);
    rst = 1'b1;
    cyc(3);
    chk("post_rst_state", 32'(bus.state_out), 32'd0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
